// File: rtl/comp_bist_if.sv
// Operand/response bus between the BIST engine and the magnitude comparator under test.
interface comp_bist_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             g;
    logic             e;
    logic             l;

    modport master (output a, output b, input g, input e, input l);
    modport slave  (input a, input b, output g, output e, output l);
endinterface

// File: rtl/comp_bist.sv
// BIST engine: sweeps every (a,b) pair of an N-bit comparator, checks g/e/l against
// a golden unsigned compare, and reports pass/fail, error count and first failing vector.
module comp_bist #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DWELL = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    comp_bist_if.master        cmp,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     vec;
    logic [CW-1:0]          cnt;
    logic                   tail;
    logic                   load, sample, finish;
    logic [WIDTH-1:0]       cur_a, cur_b;
    logic [2:0]             golden;
    logic                   mismatch;

    // a occupies the upper half so a plain increment walks a-major order
    assign cur_a = vec[2*WIDTH-1:WIDTH];
    assign cur_b = vec[WIDTH-1:0];
    assign cmp.a = cur_a;
    assign cmp.b = cur_b;

    always_comb begin
        golden = 3'b001;
        if (cur_a > cur_b)       golden = 3'b100;
        else if (cur_a == cur_b) golden = 3'b010;
    end

    assign mismatch = ({cmp.g, cmp.e, cmp.l} != golden);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sample  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tail) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (cnt == CNT_LAST) begin
                    sample = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One extra cycle after the last sample so pass reflects the final error count
    always_ff @(posedge clk) begin
        if (rst || load) begin
            vec        <= '0;
            cnt        <= '0;
            tail       <= 1'b0;
            busy       <= load;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (finish) begin
            tail <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == '0);
        end else if (state_q == RUN) begin
            if (sample) begin
                cnt <= '0;
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= cur_a;
                        fail_b     <= cur_b;
                    end
                end
                if (&vec) begin
                    vec  <= '0;
                    tail <= 1'b1;
                end else begin
                    vec <= vec + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_comp_bist.sv
// Randomized self-checking bench for comp_bist with DWELL=30 and DWELL=1 instances
// driving a table-based comparator model.
module tb_comp_bist;
    localparam int unsigned W = 2;
    localparam int unsigned NV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start30 = 1'b0;
    logic start1 = 1'b0;
    logic [2:0] resp_tbl [NV];

    logic busy30, done30, pass30, fv30, busy1, done1, pass1, fv1;
    logic [2*W:0] err30, err1;
    logic [W-1:0] fa30, fb30, fa1, fb1;

    int n_chk = 0;
    int n_err = 0;
    bit sel1 = 1'b0;

    always #5 clk = ~clk;

    comp_bist_if #(.WIDTH(W)) bus30 ();
    comp_bist_if #(.WIDTH(W)) bus1 ();

    assign {bus30.g, bus30.e, bus30.l} = resp_tbl[{bus30.a, bus30.b}];
    assign {bus1.g, bus1.e, bus1.l}    = resp_tbl[{bus1.a, bus1.b}];

    comp_bist #(.WIDTH(W), .DWELL(30)) dut30 (
        .clk(clk), .rst(rst), .start(start30), .cmp(bus30.master),
        .busy(busy30), .done(done30), .pass(pass30), .err_count(err30),
        .fail_valid(fv30), .fail_a(fa30), .fail_b(fb30)
    );

    comp_bist #(.WIDTH(W), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cmp(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    // Outputs of whichever instance the current test targets
    logic o_busy, o_done, o_pass, o_fv;
    logic [2*W:0] o_err;
    logic [W-1:0] o_a, o_b, o_fa, o_fb;
    assign o_busy = sel1 ? busy1 : busy30;
    assign o_done = sel1 ? done1 : done30;
    assign o_pass = sel1 ? pass1 : pass30;
    assign o_fv   = sel1 ? fv1   : fv30;
    assign o_err  = sel1 ? err1  : err30;
    assign o_a    = sel1 ? bus1.a : bus30.a;
    assign o_b    = sel1 ? bus1.b : bus30.b;
    assign o_fa   = sel1 ? fa1   : fa30;
    assign o_fb   = sel1 ? fb1   : fb30;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ideal(input int unsigned ai, input int unsigned bi);
        if (ai > bi)  return 3'b100;
        if (ai == bi) return 3'b010;
        return 3'b001;
    endfunction

    // mode: 0 ideal, 1 e stuck 0, 2 g/l swapped, 3 110 at (3,2), 4 random corruption
    task automatic fill_tbl(input int mode);
        for (int unsigned i = 0; i < NV; i++) begin
            logic [2:0] c;
            c = ideal(i / 4, i % 4);
            case (mode)
                1: c = c & 3'b101;
                2: c = {c[0], c[1], c[2]};
                3: if (i == 14) c = 3'b110;
                4: if ($urandom_range(3) == 0) c = 3'($urandom);
                default: ;
            endcase
            resp_tbl[i] = c;
        end
    endtask

    task automatic model(output int errs, output bit fv, output int fa, output int fb);
        errs = 0; fv = 0; fa = 0; fb = 0;
        for (int unsigned ai = 0; ai < 4; ai++)
            for (int unsigned bi = 0; bi < 4; bi++)
                if (resp_tbl[ai * 4 + bi] != ideal(ai, bi)) begin
                    if (!fv) begin
                        fv = 1; fa = int'(ai); fb = int'(bi);
                    end
                    errs++;
                end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ab"}, {o_a, o_b}, 0);
        check({pfx, "_flags"}, {o_busy, o_done, o_pass, o_fv}, 0);
        check({pfx, "_err"}, o_err, 0);
        check({pfx, "_fail_ab"}, {o_fa, o_fb}, 0);
    endtask

    task automatic pulse_start();
        if (sel1) start1 = 1'b1; else start30 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start30 = 1'b0;
    endtask

    // Full sweep: checks clearing on entry, vector order per cycle, latency and results
    task automatic run_sweep(input string tag, input bit use1, input bit poke);
        int dwell, k, mism, errs, fa, fb, idx;
        bit fv;
        sel1 = use1;
        dwell = use1 ? 1 : 30;
        model(errs, fv, fa, fb);
        @(negedge clk);
        pulse_start();
        check({tag, "_entry"}, {o_busy, o_done, o_pass, o_fv, o_fa, o_fb}, 32'b1000_0000);
        check({tag, "_entry_err"}, o_err, 0);
        k = 0; mism = 0;
        while (!o_done && k < NV * dwell + 20) begin
            idx = (k < int'(NV) * dwell) ? k / dwell : 0;
            if ({o_a, o_b} != 4'(idx)) mism++;
            if (poke && k == 100) begin
                if (use1) start1 = 1'b1; else start30 = 1'b1;
            end
            if (poke && k == 101) begin
                start1 = 1'b0; start30 = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start1 = 1'b0; start30 = 1'b0;
        check({tag, "_latency"}, k, NV * dwell + 1);
        check({tag, "_seq"}, mism, 0);
        check({tag, "_done_ab"}, {o_busy, o_done, o_a, o_b}, 32'b01_0000);
        check({tag, "_err"}, o_err, errs);
        check({tag, "_pass"}, o_pass, (errs == 0));
        check({tag, "_fv"}, o_fv, fv);
        check({tag, "_fail_ab"}, {o_fa, o_fb}, {fa[1:0], fb[1:0]});
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold"}, {o_done, o_pass, o_err}, {1'b1, 1'(errs == 0), 5'(errs)});
    endtask

    initial begin
        int mode;
        fill_tbl(0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset30");
        sel1 = 1'b1;
        check_zero("reset1");
        rst = 1'b0;

        fill_tbl(0); run_sweep("ideal30", 1'b0, 1'b0);
        fill_tbl(1); run_sweep("estuck30", 1'b0, 1'b0);
        fill_tbl(2); run_sweep("swap30", 1'b0, 1'b1);
        fill_tbl(3); run_sweep("one110_30", 1'b0, 1'b0);
        fill_tbl(0); run_sweep("ideal1", 1'b1, 1'b0);
        fill_tbl(2); run_sweep("swap1", 1'b1, 1'b1);
        fill_tbl(3); run_sweep("one110_1", 1'b1, 1'b0);

        // Mid-sweep reset with errors already accumulated
        fill_tbl(1);
        sel1 = 1'b0;
        @(negedge clk);
        pulse_start();
        repeat (199) @(posedge clk);
        #1;
        check("pre_rst_err", (o_err != 0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midrst");
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_rst", {o_busy, o_done, o_a, o_b}, 0);
        fill_tbl(0); run_sweep("post_rst", 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            mode = 4;
            fill_tbl(mode);
            run_sweep($sformatf("rand%0d", i), (i % 2) == 1, (i % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/comp_bist.md
Name: comp_bist

Overview:
- Synthesizable built-in self-test engine for an N-bit magnitude comparator with outputs g/e/l.
- Drives the comparator's a/b inputs through every operand pair and samples its g/e/l outputs.
- Checks each sample against a golden compare, then reports pass/fail, error count and the first failing vector.
- Sits beside the comparator instance and replaces the simulation-only stimulus bench in hardware.

Parameters:
- WIDTH, 2, operand width of the comparator under test (1..8).
- DWELL, 30, clock cycles each vector is held before sampling (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- a  output  WIDTH  operand A to the comparator.
- b  output  WIDTH  operand B to the comparator.
- g  input  1  comparator "a>b" response.
- e  input  1  comparator "a==b" response.
- l  input  1  comparator "a<b" response.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start or rst.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  2*WIDTH+1  number of failing vectors.
- fail_valid  output  1  at least one failure recorded.
- fail_a  output  WIDTH  A operand of the first failing vector.
- fail_b  output  WIDTH  B operand of the first failing vector.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: a, b, busy, done, pass, err_count, fail_valid, fail_a, fail_b.
  - rst overrides start and applies mid-sweep; the sweep is abandoned with no partial result retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge moves to RUN on the next cycle.
  - On that transition: a=0, b=0, dwell counter=0, busy=1, done=0, pass=0, err_count=0, fail_valid=0, fail_a=0, fail_b=0.
- RUN, vector ordering:
  - a is the outer loop, b the inner loop: (0,0),(0,1)..(0,max),(1,0)..(max,max).
  - Total 2^(2*WIDTH) vectors.
- RUN, dwell and sampling:
  - Dwell counter increments every cycle.
  - When it equals DWELL-1, g/e/l are sampled on that edge and compared.
  - On the same edge the next vector is applied and the counter clears.
  - Each vector is therefore stable on a/b for exactly DWELL cycles.
- Golden compare:
  - Unsigned compare of the registered a/b currently driven.
  - Expected {g,e,l} = 100 if a>b, 010 if a==b, 001 if a<b.
  - Any other sampled code (including 000, 110, 111) is a failure.
- On failure:
  - err_count increments.
  - If fail_valid==0: set fail_valid=1 and capture fail_a/fail_b from the current a/b.
  - Later failures do not overwrite fail_a/fail_b.
- Last vector:
  - After sampling (max,max), go to DONE.
  - busy=0, done=1, pass=(final err_count==0).
  - a/b return to 0.
  - err_count, fail_* and pass hold their values.
- Latency: done rises exactly 2^(2*WIDTH)*DWELL + 1 cycles after the edge that accepted start.
- DONE: start=1 restarts exactly as from IDLE, clearing results on entry to RUN.
- start during RUN is ignored; there is no abort other than rst.
- err_count cannot overflow; its width holds 2^(2*WIDTH).
- DWELL=1: a new vector every cycle and a sample every cycle, with no idle cycles between vectors.

Test Plan:
- Ideal comparator model, WIDTH=2, DWELL=30, start pulse:
  - a/b step through 16 pairs, 30 cycles each, a-major order.
  - done rises 481 cycles after start.
  - pass=1, err_count=0, fail_valid=0.
- Faulty model with e stuck at 0:
  - err_count=4, pass=0, fail_valid=1, fail_a=0, fail_b=0.
- Faulty model with g and l swapped:
  - err_count=12, fail_a=0, fail_b=1.
  - e-only vectors pass.
- Model outputting 110 only when a=3, b=2:
  - err_count=1, fail_a=3, fail_b=2.
- Assert rst at cycle 200 of a run, then hold start low:
  - Next cycle: all outputs 0, state IDLE.
  - New start gives a full clean 481-cycle sweep with correct results.
- Protocol and timing corners:
  - Pulse start during RUN: no effect on a/b sequence or done timing.
  - start in DONE: restarts and clears results.
  - DWELL=1: done at cycle 17, vector changes every cycle, results identical to DWELL=30.
